// File: rtl/fu_result_buffer_pkg.sv
// Shared types and constants for the FU result buffer: the CDB entry struct,
// its reset value, machine sizes and modular ROB distance.
package fu_result_buffer_pkg;

   localparam int NUM_ROB = 32;
   localparam int NUM_PR  = 64;
   localparam int ROB_W   = $clog2(NUM_ROB);
   localparam int PR_W    = $clog2(NUM_PR);

   localparam logic [PR_W-1:0] ZERO_PR  = {PR_W{1'b0}};
   localparam logic [4:0]      ZERO_REG = 5'd0;

   typedef struct packed {
      logic             done;
      logic [PR_W-1:0]  T_idx;
      logic [ROB_W-1:0] ROB_idx;
      logic [4:0]       dest_idx;
      logic [63:0]      result;
   } FU_RESULT_t;

   localparam FU_RESULT_t FU_RESULT_RESET = '{1'b0, ZERO_PR, {ROB_W{1'b0}}, ZERO_REG, 64'd0};

   // (a - b) mod NUM_ROB; also correct when NUM_ROB is not a power of two
   function automatic logic [ROB_W-1:0] rob_dist(input logic [ROB_W-1:0] a,
                                                 input logic [ROB_W-1:0] b);
      logic [ROB_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[ROB_W]) begin
         d = d + (ROB_W+1)'(NUM_ROB);
      end else begin
         d = d;
      end
      return d[ROB_W-1:0];
   endfunction

endpackage

// File: rtl/fu_result_buffer_chk.sv
// Protocol checker for fu_result_buffer: flags a result offered while the
// buffer reports it cannot accept one (that result is dropped by the buffer).
module fu_result_buffer_chk (
   input logic clock,
   input logic reset,
   input logic fu_valid,
   input logic fu_ready
);

   // result offered while not ready is lost
   a_no_push_when_full : assert property (@(posedge clock) disable iff (reset) !(fu_valid && !fu_ready))
      else $warning("fu_result_buffer: fu_valid asserted while fu_ready=0, result dropped");

endmodule

// File: rtl/fu_result_buffer_rob_squash_chk.sv
// Combinational squash test: an entry is squashed when it lies within
// diff_rob slots after the rollback point, using wrapping ROB distance.
module rob_squash_chk
   import fu_result_buffer_pkg::*;
(
   input  logic             rollback_en,
   input  logic [ROB_W-1:0] rob_idx,
   input  logic [ROB_W-1:0] rollback_idx,
   input  logic [ROB_W-1:0] diff_rob,
   output logic             sq
);

   assign sq = rollback_en && (rob_dist(rob_idx, rollback_idx) <= diff_rob);

endmodule

// File: rtl/fu_result_buffer.sv
// FU-side CDB transmitter: FIFO of completed results with rollback squash.
// Optional same-cycle bypass of an empty queue under FU_RESULT_BYPASS_EN.
module fu_result_buffer
   import fu_result_buffer_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             fu_valid,
   input  logic [PR_W-1:0]  fu_T_idx,
   input  logic [ROB_W-1:0] fu_ROB_idx,
   input  logic [4:0]       fu_dest_idx,
   input  logic [63:0]      fu_result,
   input  logic             rollback_en,
   input  logic [ROB_W-1:0] ROB_rollback_idx,
   input  logic [ROB_W-1:0] diff_ROB,
   input  logic             CDB_valid,
   output FU_RESULT_t       FU_out,
   output logic             fu_ready,
   output logic [CNT_W-1:0] count
);

   FU_RESULT_t       entry_r    [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [CNT_W-1:0] count_r;

   FU_RESULT_t       entry_nx_s [DEPTH];
   logic [DEPTH-1:0] valid_nx_s;
   logic [CNT_W-1:0] count_nx_s;
   logic [DEPTH-1:0] sq_s;
   logic             sq_in_s;
   logic             head_done_s;
   logic             byp_s;
   logic             pop_s;
   logic             push_s;
   FU_RESULT_t       in_s;

   for (genvar g = 0; g < DEPTH; g++) begin : g_sq
      rob_squash_chk u_sq (
         .rollback_en  (rollback_en),
         .rob_idx      (entry_r[g].ROB_idx),
         .rollback_idx (ROB_rollback_idx),
         .diff_rob     (diff_ROB),
         .sq           (sq_s[g])
      );
   end

   rob_squash_chk u_sq_in (
      .rollback_en  (rollback_en),
      .rob_idx      (fu_ROB_idx),
      .rollback_idx (ROB_rollback_idx),
      .diff_rob     (diff_ROB),
      .sq           (sq_in_s)
   );

   assign in_s        = '{1'b1, fu_T_idx, fu_ROB_idx, fu_dest_idx, fu_result};
   assign head_done_s = valid_r[0] && !sq_s[0];
   assign fu_ready    = (count_r < CNT_W'(DEPTH));
   assign count       = count_r;

`ifdef FU_RESULT_BYPASS_EN
   assign byp_s = !valid_r[0] && fu_valid && !sq_in_s;
`else
   assign byp_s = 1'b0;
`endif

   // Present the head (or the bypassed input); a squashed head never shows done
   always_comb begin
      FU_out = entry_r[0];
      if (byp_s) begin
         FU_out = in_s;
      end else begin
         FU_out.done = head_done_s;
      end
   end

   // A bypassed result that the CDB takes this edge is never enqueued
   assign pop_s  = en && FU_out.done && CDB_valid;
   assign push_s = en && fu_valid && fu_ready && !sq_in_s && !(byp_s && CDB_valid);

   // Drop popped/squashed entries, compact survivors in order, append push
   always_comb begin
      logic [CNT_W-1:0] idx;
      entry_nx_s = entry_r;
      valid_nx_s = {DEPTH{1'b0}};
      idx        = {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_r[i] && !sq_s[i] && !((i == 0) && pop_s)) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (CNT_W'(j) == idx) begin
                  entry_nx_s[j] = entry_r[i];
                  valid_nx_s[j] = 1'b1;
               end else begin
                  valid_nx_s[j] = valid_nx_s[j];
               end
            end
            idx = idx + CNT_W'(1);
         end else begin
            idx = idx;
         end
      end
      if (push_s) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j) == idx) begin
               entry_nx_s[j] = in_s;
               valid_nx_s[j] = 1'b1;
            end else begin
               valid_nx_s[j] = valid_nx_s[j];
            end
         end
         idx = idx + CNT_W'(1);
      end else begin
         idx = idx;
      end
      count_nx_s = idx;
   end

   // Queue state: reset wins over everything, en freezes all updates
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_r[i] <= FU_RESULT_RESET;
         end
         valid_r <= {DEPTH{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         entry_r <= entry_nx_s;
         valid_r <= valid_nx_s;
         count_r <= count_nx_s;
      end
   end

endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed bench for fu_result_buffer with a scoreboard of expected CDB
// results; expectations adapt to FU_RESULT_BYPASS_EN when defined.
module tb_fu_result_buffer;
   import fu_result_buffer_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH+1);
`ifdef FU_RESULT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             en;
   logic             fu_valid;
   logic [PR_W-1:0]  fu_T_idx;
   logic [ROB_W-1:0] fu_ROB_idx;
   logic [4:0]       fu_dest_idx;
   logic [63:0]      fu_result;
   logic             rollback_en;
   logic [ROB_W-1:0] ROB_rollback_idx;
   logic [ROB_W-1:0] diff_ROB;
   logic             CDB_valid;
   FU_RESULT_t       FU_out;
   logic             fu_ready;
   logic [CNT_W-1:0] count;

   int         n_checks = 0;
   int         n_err    = 0;
   FU_RESULT_t sb[$];

   always #5 clock = ~clock;

   fu_result_buffer #(.DEPTH(DEPTH)) dut (
      .clock            (clock),
      .reset            (reset),
      .en               (en),
      .fu_valid         (fu_valid),
      .fu_T_idx         (fu_T_idx),
      .fu_ROB_idx       (fu_ROB_idx),
      .fu_dest_idx      (fu_dest_idx),
      .fu_result        (fu_result),
      .rollback_en      (rollback_en),
      .ROB_rollback_idx (ROB_rollback_idx),
      .diff_ROB         (diff_ROB),
      .CDB_valid        (CDB_valid),
      .FU_out           (FU_out),
      .fu_ready         (fu_ready),
      .count            (count)
   );

   fu_result_buffer_chk u_chk (
      .clock    (clock),
      .reset    (reset),
      .fu_valid (fu_valid),
      .fu_ready (fu_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic FU_RESULT_t mk(input int t, input int rob, input int dest, input logic [63:0] res);
      FU_RESULT_t e;
      e = '{1'b1, PR_W'(t), ROB_W'(rob), 5'(dest), res};
      return e;
   endfunction

   task automatic nxt();
      @(negedge clock);
   endtask

   task automatic drv(input int t, input int rob, input int dest, input logic [63:0] res, input logic cdb);
      fu_valid    = 1'b1;
      fu_T_idx    = PR_W'(t);
      fu_ROB_idx  = ROB_W'(rob);
      fu_dest_idx = 5'(dest);
      fu_result   = res;
      CDB_valid   = cdb;
   endtask

   task automatic idle(input logic cdb);
      fu_valid  = 1'b0;
      CDB_valid = cdb;
   endtask

   task automatic rb(input logic on, input int idx, input int diff);
      rollback_en      = on;
      ROB_rollback_idx = ROB_W'(idx);
      diff_ROB         = ROB_W'(diff);
   endtask

   // Settle, then compare whatever the CDB captures at the coming edge
   task automatic look();
      FU_RESULT_t e;
      #2;
      if (FU_out.done && CDB_valid && en) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_pop", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("sb_T_idx",    64'(FU_out.T_idx),    64'(e.T_idx));
            chk("sb_ROB_idx",  64'(FU_out.ROB_idx),  64'(e.ROB_idx));
            chk("sb_dest_idx", 64'(FU_out.dest_idx), 64'(e.dest_idx));
            chk("sb_result",   FU_out.result,        e.result);
         end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; fu_valid = 1'b0; fu_T_idx = '0; fu_ROB_idx = '0;
      fu_dest_idx = 5'd0; fu_result = 64'd0; CDB_valid = 1'b0;
      rb(1'b0, 0, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #2;
      chk("rst_count",    64'(count),           64'd0);
      chk("rst_done",     64'(FU_out.done),     64'd0);
      chk("rst_ready",    64'(fu_ready),        64'd1);
      chk("rst_T_idx",    64'(FU_out.T_idx),    64'(ZERO_PR));
      chk("rst_dest_idx", 64'(FU_out.dest_idx), 64'(ZERO_REG));
      chk("rst_ROB_idx",  64'(FU_out.ROB_idx),  64'd0);
      chk("rst_result",   FU_out.result,        64'd0);

      // 1: single result, CDB free
      nxt(); drv(5, 3, 7, 64'h1111, 1'b1); sb.push_back(mk(5, 3, 7, 64'h1111)); look();
      chk("t1_done_now", 64'(FU_out.done), 64'(BYP));
      nxt(); idle(1'b1); look();
      chk("t1_done_next", 64'(FU_out.done), 64'(!BYP));
      nxt(); look();
      chk("t1_count", 64'(count), 64'd0);
      chk("t1_done_end", 64'(FU_out.done), 64'd0);

      // 2: fill while CDB busy, then drain in order
      nxt(); drv(10, 3, 1, 64'hAAAA_0003, 1'b0); sb.push_back(mk(10, 3, 1, 64'hAAAA_0003)); look();
      nxt(); drv(11, 4, 2, 64'hBBBB_0004, 1'b0); sb.push_back(mk(11, 4, 2, 64'hBBBB_0004)); look();
      nxt(); idle(1'b0); look();
      chk("t2_count_full", 64'(count), 64'd2);
      chk("t2_ready_full", 64'(fu_ready), 64'd0);
      chk("t2_done", 64'(FU_out.done), 64'd1);
      nxt(); idle(1'b1); look();
      chk("t2_head_rob3", 64'(FU_out.ROB_idx), 64'd3);
      nxt(); idle(1'b1); look();
      chk("t2_head_rob4", 64'(FU_out.ROB_idx), 64'd4);
      chk("t2_count_1", 64'(count), 64'd1);
      nxt(); idle(1'b0); look();
      chk("t2_count_0", 64'(count), 64'd0);

      // 3: rollback squashes the younger ROB 9, keeps ROB 6
      nxt(); drv(20, 6, 3, 64'hC6, 1'b0); sb.push_back(mk(20, 6, 3, 64'hC6)); look();
      nxt(); drv(21, 9, 4, 64'hD9, 1'b0); sb.push_back(mk(21, 9, 4, 64'hD9)); look();
      nxt(); idle(1'b0); rb(1'b1, 7, 4); look();
      chk("t3_done_rb", 64'(FU_out.done), 64'd1);
      chk("t3_head_rb", 64'(FU_out.ROB_idx), 64'd6);
      void'(sb.pop_back());
      nxt(); rb(1'b0, 0, 0); look();
      chk("t3_count", 64'(count), 64'd1);
      chk("t3_head", 64'(FU_out.ROB_idx), 64'd6);
      nxt(); idle(1'b1); look();
      nxt(); idle(1'b0); look();
      chk("t3_count_0", 64'(count), 64'd0);

      // 4: wrapping distance squashes the head in the rollback cycle
      nxt(); drv(30, 1, 5, 64'hE1, 1'b0); sb.push_back(mk(30, 1, 5, 64'hE1)); look();
      nxt(); idle(1'b0); rb(1'b1, 30, 5); look();
      chk("t4_done_rb", 64'(FU_out.done), 64'd0);
      void'(sb.pop_back());
      nxt(); rb(1'b0, 0, 0); look();
      chk("t4_count", 64'(count), 64'd0);
      chk("t4_done", 64'(FU_out.done), 64'd0);

      // 5: full + pop + offered push -> push refused; en=0 freezes
      nxt(); drv(40, 10, 6, 64'hF10, 1'b0); sb.push_back(mk(40, 10, 6, 64'hF10)); look();
      nxt(); drv(41, 11, 7, 64'hF11, 1'b0); sb.push_back(mk(41, 11, 7, 64'hF11)); look();
      nxt(); drv(42, 12, 8, 64'hF12, 1'b1); look();
      chk("t5_ready", 64'(fu_ready), 64'd0);
      chk("t5_count_full", 64'(count), 64'd2);
      nxt(); idle(1'b0); look();
      chk("t5_count_after", 64'(count), 64'd1);
      chk("t5_head_rob11", 64'(FU_out.ROB_idx), 64'd11);
      nxt(); drv(43, 13, 9, 64'hF13, 1'b0); sb.push_back(mk(43, 13, 9, 64'hF13)); look();
      nxt(); en = 1'b0; drv(44, 14, 10, 64'hF14, 1'b1); look();
      chk("t5_en0_done", 64'(FU_out.done), 64'd1);
      nxt(); look();
      chk("t5_en0_count", 64'(count), 64'd2);
      chk("t5_en0_head", 64'(FU_out.ROB_idx), 64'd11);
      nxt(); en = 1'b1; idle(1'b1); look();
      nxt(); look();
      chk("t5_head_rob13", 64'(FU_out.ROB_idx), 64'd13);
      nxt(); idle(1'b0); look();
      chk("t5_count_0", 64'(count), 64'd0);

      // reset mid-operation beats a concurrent push
      nxt(); drv(45, 15, 11, 64'h45, 1'b0); look();
      nxt(); reset = 1'b1; drv(46, 16, 12, 64'h46, 1'b0); look();
      nxt(); reset = 1'b0; idle(1'b0); look();
      chk("rst2_count", 64'(count), 64'd0);
      chk("rst2_done", 64'(FU_out.done), 64'd0);
      chk("rst2_ready", 64'(fu_ready), 64'd1);

      // 6: empty queue latency (bypass or one cycle)
      nxt(); drv(50, 2, 3, 64'h5002, 1'b1); sb.push_back(mk(50, 2, 3, 64'h5002)); look();
      chk("t6_done_now", 64'(FU_out.done), 64'(BYP));
      nxt(); idle(1'b1); look();
      chk("t6_done_next", 64'(FU_out.done), 64'(!BYP));
      chk("t6_count_next", 64'(count), 64'(!BYP));
      nxt(); idle(1'b0); look();
      chk("t6_count_0", 64'(count), 64'd0);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
